nn_frame_sequencer: RTL

Frame-level controller for the `nn` digit-recognition core. It accepts a stream of `WIDTH` pixels over a valid/ready handshake and resets the core before each frame. It drives the core's `pixel_counter`/`input_pixel` inputs one pixel per accepted beat, waits out the core's fixed post-frame latency, then captures `predict_num` and reports completion. It sits between the register/DMA front end and `nn`, replacing software-driven per-pixel register writes.

---
 rtl/nn_frame_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/nn_frame_sequencer.sv
// Frame-level controller for the nn digit-recognition core: resets the core,
// streams WIDTH pixels into it, waits out its latency and captures the prediction.
module nn_frame_sequencer #(
    parameter int unsigned WIDTH         = 784,
    parameter int unsigned CNT_BITS      = 10,
    parameter int unsigned PIX_BITS      = 24,
    parameter int unsigned RES_BITS      = 24,
    parameter int unsigned NN_RST_CYCLES = 2,
    parameter int unsigned NN_LATENCY    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                pix_valid,
    input  logic [PIX_BITS-1:0] pix_data,
    output logic                pix_ready,
    output logic                nn_reset,
    output logic [CNT_BITS-1:0] nn_pixel_counter,
    output logic [PIX_BITS-1:0] nn_input_pixel,
    input  logic [RES_BITS-1:0] nn_predict_num,
    output logic                busy,
    output logic                done,
    output logic [RES_BITS-1:0] result,
    output logic [15:0]         frame_count
);

    localparam int unsigned TMAX  = (NN_RST_CYCLES > NN_LATENCY) ? NN_RST_CYCLES : NN_LATENCY;
    localparam int unsigned TBITS = $clog2(TMAX + 1);

    localparam logic [CNT_BITS-1:0] IDLE_IDX = CNT_BITS'(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(WIDTH - 1);
    localparam logic [TBITS-1:0]    RST_LAST = TBITS'(NN_RST_CYCLES - 1);
    localparam logic [TBITS-1:0]    LAT_LAST = TBITS'(NN_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TBITS-1:0]    timer;
    logic [CNT_BITS-1:0] idx;
    logic                beat;
    logic                capture;

    // pix_ready is high exactly in FEED, so FEED alone qualifies a beat
    assign beat    = (state == S_FEED) && pix_valid && !abort;
    assign capture = (state == S_DRAIN) && (state_nxt == S_CAPTURE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (abort)                  state_nxt = S_IDLE;
                else if (timer == RST_LAST) state_nxt = S_FEED;
            end
            S_FEED: begin
                if (abort)                          state_nxt = S_IDLE;
                else if (beat && idx == LAST_IDX)   state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                  state_nxt = S_IDLE;
                else if (timer == LAT_LAST) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt != state) ? '0 : timer + 1'b1;
            if (state == S_CLEAR) idx <= '0;
            else if (beat)        idx <= idx + 1'b1;
        end
    end

    // Outputs are registered from the next-state decode so they line up with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_ready        <= 1'b0;
            nn_reset         <= 1'b1;
            busy             <= 1'b0;
            nn_pixel_counter <= IDLE_IDX;
            nn_input_pixel   <= '0;
            done             <= 1'b0;
            result           <= '0;
            frame_count      <= '0;
        end else begin
            pix_ready        <= (state_nxt == S_FEED);
            nn_reset         <= (state_nxt == S_CLEAR);
            busy             <= (state_nxt != S_IDLE);
            nn_pixel_counter <= beat ? idx : IDLE_IDX;
            if (beat) nn_input_pixel <= pix_data;
            done             <= capture;
            if (capture) begin
                result      <= nn_predict_num;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
